memory_game_ctrl: RTL and testbench
===================================

Name: memory_game_ctrl

Overview:
Round controller for the switch/LED memory game. On start it draws a pseudo-random LED sequence of length difficulty+3, plays it on the LEDs at a difficulty-dependent rate, then checks the player's switch toggles against it. It reports win/lose, keeps a saturating score, and sits between the board I/O (SW, LEDR) and the 7-segment score decoder.

Parameters:
NUM_SW, 10, number of switches/LEDs; sequence positions 0..NUM_SW-1
MAX_LEN, 6, sequence storage depth; must be >= 3+3
TICK_DIV, 25000000, base show time in clk cycles at difficulty 0; must be >= 8
TIMEOUT_TICKS, 10, INPUT-phase inactivity limit in units of TICK_DIV cycles
SEED, 8'hA5, LFSR value loaded at reset; must be nonzero

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle start/restart request (already debounced)
difficulty  in  2  0..3; sampled only when a round starts
sw  in  NUM_SW  raw board switches (asynchronous)
led  out  NUM_SW  LED drive
score  out  8  rounds won, saturating at 255
success  out  1  high while in WIN
fail  out  1  high while in LOSE
busy  out  1  high in GEN, SHOW_ON, SHOW_OFF and INPUT
step  out  3  index of the current sequence element being shown or expected

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; led=0, score=0, success=0, fail=0, busy=0, step=0; lfsr=SEED; edge-detect history = current synchronised sw.
- sw passes through a 2-FF synchroniser, then edge detection (sync vs previous). Event = exactly one bit changed → valid toggle at that index. More than one bit changed in the same cycle → invalid toggle. History updates every cycle in every state.
- len = difficulty_latched+3. show_cycles = TICK_DIV >> difficulty_latched.
- IDLE: led=0. start → GEN; latch difficulty; step=0.
- GEN: one element per cycle. lfsr <= (lfsr>>1) ^ (lfsr[0] ? 8'hB8 : 0). Element = n<10 ? n : n-10, where n = new lfsr[3:0]. Stored in seq[step]. After len cycles: step=0, timer=0, go to SHOW_ON.
- SHOW_ON: led = one-hot(seq[step]) for show_cycles cycles, then SHOW_OFF.
- SHOW_OFF: led=0 for show_cycles cycles. Then step+1; if step==len-1, step=0, timer=0 and go to INPUT; else SHOW_ON.
- INPUT: led=0. Toggles arriving before INPUT are ignored.
  - Valid toggle at index == seq[step]: step+1, timer=0, led echoes one-hot(index) for 1 cycle. Last element → WIN.
  - Valid toggle at the wrong index, or invalid toggle → LOSE.
  - No toggle for TIMEOUT_TICKS*TICK_DIV cycles → LOSE.
- WIN: on entry, score = min(score+1, 255). success=1, led all ones.
- LOSE: fail=1, led=0, score unchanged.
- In WIN or LOSE, start → GEN with difficulty re-latched. success/fail drop on the same edge.
- start is ignored while busy. Toggles outside INPUT are consumed and never queued.
- A toggle and a timeout expiring in the same cycle: the toggle wins.
- reset low in any state aborts the round on that edge and returns to the reset values. The LFSR reloads SEED.
- Latency: start at edge k → GEN at k+1 → first SHOW_ON cycle at k+1+len. A sw change reaches the comparator 3 cycles after it is sampled (2 sync + 1 edge).
- All outputs are registered.

Decomposition:
- Package memory_game_pkg: state enum (IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE), LFSR tap constant 8'hB8, default SEED, NUM_SW/MAX_LEN defaults.
- One sub-module, sw_edge_detect: synchroniser, history and one-hot/invalid decode. Outputs valid, invalid and idx.

Test Plan:
- TICK_DIV=8, difficulty=0, start after reset → seq 0,5,2. LED pattern: 10'h001 for 8 cycles, 0 for 8, 10'h020, 0, 10'h004, 0. busy=1 throughout.
- Same round, toggle sw[0], sw[5], sw[2] in INPUT → WIN, success=1, led=10'h3FF, score=1. Start again → busy=1, success=0 on the next cycle.
- Fresh reset, difficulty=1, start → len=4, seq 0,5,2,1, show_cycles=4. Toggle sw[0] then sw[3] → LOSE, fail=1, score=0.
- Toggle sw[4] and sw[7] in the same cycle during INPUT → LOSE. Toggles during SHOW_ON → ignored, no LOSE.
- TICK_DIV=8, TIMEOUT_TICKS=2, no toggles in INPUT → LOSE exactly 16 cycles after INPUT entry. A toggle on cycle 16 instead → accepted.
- Force score=255 via 255 wins (or backdoor), then win again → score stays 255. Drive reset low mid-SHOW_ON → next cycle IDLE, led=0, score=0.

Source files
------------

// File: rtl/memory_game_pkg.sv
// Shared types and constants for the switch/LED memory game round controller.
package memory_game_pkg;

  typedef enum logic [2:0] {
    IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE
  } state_t;

  localparam logic [7:0] LFSR_TAPS   = 8'hB8;
  localparam logic [7:0] DEF_SEED    = 8'hA5;
  localparam int         DEF_NUM_SW  = 10;
  localparam int         DEF_MAX_LEN = 6;
  localparam int         IDX_W       = 4;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

  // Fold the low nibble onto 0..9 so every value names a real switch.
  function automatic logic [IDX_W-1:0] elem_of(input logic [7:0] s);
    return (s[3:0] < 4'd10) ? s[3:0] : s[3:0] - 4'd10;
  endfunction

endpackage

// File: rtl/memory_game_ctrl_sw_edge_detect.sv
// Switch synchroniser and single-toggle decoder; one registered event per cycle.
module sw_edge_detect
  import memory_game_pkg::*;
#(
  parameter int NUM_SW = DEF_NUM_SW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw,
  output logic              valid,
  output logic              invalid,
  output logic [IDX_W-1:0]  idx
);

  logic [NUM_SW-1:0] sync1, sync2, hist, diff;
  logic              onehot;
  logic [IDX_W-1:0]  enc;

  assign diff = sync2 ^ hist;

  always_comb begin
    onehot = (diff != '0) && ((diff & (diff - NUM_SW'(1))) == '0);
    enc    = '0;
    for (int i = 0; i < NUM_SW; i++)
      if (diff[i]) enc = IDX_W'(i);
  end

  // History tracks the synchronised switches even in reset, so no stale edge survives it.
  always_ff @(posedge clk) begin
    sync1 <= sw;
    sync2 <= sync1;
    hist  <= sync2;
    if (!reset) begin
      valid   <= 1'b0;
      invalid <= 1'b0;
      idx     <= '0;
    end else begin
      valid   <= onehot;
      invalid <= (diff != '0) && !onehot;
      idx     <= enc;
    end
  end

endmodule

// File: rtl/memory_game_ctrl.sv
// Memory game round FSM: generate, show, and check an LED sequence; keep score.
module memory_game_ctrl
  import memory_game_pkg::*;
#(
  parameter int         NUM_SW        = DEF_NUM_SW,
  parameter int         MAX_LEN       = DEF_MAX_LEN,
  parameter int         TICK_DIV      = 25000000,
  parameter int         TIMEOUT_TICKS = 10,
  parameter logic [7:0] SEED          = DEF_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        difficulty,
  input  logic [NUM_SW-1:0] sw,
  output logic [NUM_SW-1:0] led,
  output logic [7:0]        score,
  output logic              success,
  output logic              fail,
  output logic              busy,
  output logic [2:0]        step
);

  localparam logic [31:0] TO_CYC = 32'(TIMEOUT_TICKS * TICK_DIV);

  state_t                          state, state_n;
  logic [2:0]                      step_n, len;
  logic [31:0]                     timer, timer_n, show_cyc;
  logic [7:0]                      lfsr, lfsr_n, score_n;
  logic [1:0]                      diff_l, diff_n;
  logic [MAX_LEN-1:0][IDX_W-1:0]   seq, seq_n;
  logic [NUM_SW-1:0]               led_n;
  logic                            tog_valid, tog_invalid;
  logic [IDX_W-1:0]                tog_idx;

  function automatic logic [NUM_SW-1:0] dec(input logic [IDX_W-1:0] i);
    return NUM_SW'(1) << i;
  endfunction

  sw_edge_detect #(.NUM_SW(NUM_SW)) u_edge (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .valid   (tog_valid),
    .invalid (tog_invalid),
    .idx     (tog_idx)
  );

  assign len      = {1'b0, diff_l} + 3'd3;
  assign show_cyc = 32'(TICK_DIV) >> diff_l;

  always_comb begin
    state_n = state;
    step_n  = step;
    timer_n = timer;
    lfsr_n  = lfsr;
    diff_n  = diff_l;
    seq_n   = seq;
    score_n = score;
    led_n   = '0;
    unique case (state)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_n = GEN;
          diff_n  = difficulty;
          step_n  = '0;
        end
      end
      GEN: begin
        lfsr_n      = lfsr_next(lfsr);
        seq_n[step] = elem_of(lfsr_n);
        if (step == len - 3'd1) begin
          step_n  = '0;
          timer_n = '0;
          state_n = SHOW_ON;
        end else begin
          step_n = step + 3'd1;
        end
      end
      SHOW_ON: begin
        if (timer == show_cyc - 32'd1) begin
          timer_n = '0;
          state_n = SHOW_OFF;
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      SHOW_OFF: begin
        if (timer == show_cyc - 32'd1) begin
          timer_n = '0;
          if (step == len - 3'd1) begin
            step_n  = '0;
            state_n = INPUT;
          end else begin
            step_n  = step + 3'd1;
            state_n = SHOW_ON;
          end
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      INPUT: begin
        // A toggle landing on the final timeout cycle is still honoured.
        if (tog_valid && tog_idx == seq[step]) begin
          led_n   = dec(tog_idx);
          timer_n = '0;
          step_n  = step + 3'd1;
          if (step == len - 3'd1) begin
            state_n = WIN;
            score_n = (score == 8'hFF) ? score : score + 8'd1;
          end
        end else if (tog_valid || tog_invalid) begin
          state_n = LOSE;
        end else if (timer == TO_CYC - 32'd1) begin
          state_n = LOSE;
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == SHOW_ON) led_n = dec(seq_n[step_n]);
    if (state_n == WIN)     led_n = '1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      step    <= '0;
      timer   <= '0;
      lfsr    <= SEED;
      diff_l  <= '0;
      seq     <= '0;
      led     <= '0;
      score   <= '0;
      success <= 1'b0;
      fail    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      step    <= step_n;
      timer   <= timer_n;
      lfsr    <= lfsr_n;
      diff_l  <= diff_n;
      seq     <= seq_n;
      led     <= led_n;
      score   <= score_n;
      success <= (state_n == WIN);
      fail    <= (state_n == LOSE);
      busy    <= (state_n inside {GEN, SHOW_ON, SHOW_OFF, INPUT});
    end
  end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl with an LFSR sequence model and scoreboard queues.
module tb_memory_game_ctrl;

  localparam int NSW = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     difficulty = 2'd0;
  logic [NSW-1:0] sw = '0;
  logic [NSW-1:0] led;
  logic [7:0]     score;
  logic           success, fail, busy;
  logic [2:0]     step;

  int errors = 0;
  int checks = 0;
  logic [7:0] m_lfsr;
  int m_score, m_len, m_sc, e;
  int show_q[$];
  int in_q[$];

  memory_game_ctrl #(
    .NUM_SW(NSW), .MAX_LEN(6), .TICK_DIV(8), .TIMEOUT_TICKS(2), .SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .difficulty(difficulty), .sw(sw),
    .led(led), .score(score), .success(success), .fail(fail), .busy(busy), .step(step)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] m_next(input logic [7:0] s);
    logic [7:0] r;
    r = {1'b0, s[7:1]};
    if (s[0]) r = r ^ 8'hB8;
    return r;
  endfunction

  function automatic int m_elem(input logic [7:0] s);
    int n;
    n = int'(s[3:0]);
    return (n < 10) ? n : n - 10;
  endfunction

  function automatic logic [NSW-1:0] m_oh(input int b);
    logic [NSW-1:0] r;
    r = '0;
    r[b] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle(input int b);
    sw[b] = ~sw[b];
    repeat (4) tick();
  endtask

  // Start a round, push the modelled sequence, and walk through GEN.
  task automatic do_start(input int d);
    logic ok;
    difficulty = 2'(d);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_len = d + 3;
    m_sc  = 8 >> d;
    for (int i = 0; i < m_len; i++) begin
      m_lfsr = m_next(m_lfsr);
      show_q.push_back(m_elem(m_lfsr));
      in_q.push_back(m_elem(m_lfsr));
    end
    chk("start_busy", busy, 1);
    chk("start_success", success, 0);
    chk("start_fail", fail, 0);
    ok = 1'b1;
    for (int i = 0; i < m_len; i++) begin
      ok &= (led === '0) && (busy === 1'b1);
      tick();
    end
    chk("gen_phase", ok, 1);
  endtask

  // Each element must be lit for exactly m_sc cycles, then dark for m_sc cycles.
  task automatic watch_show(input bit poke);
    logic on_ok, off_ok;
    int x;
    for (int i = 0; i < m_len; i++) begin
      x = show_q.pop_front();
      on_ok = 1'b1;
      off_ok = 1'b1;
      for (int c = 0; c < m_sc; c++) begin
        on_ok &= (led === m_oh(x)) && (busy === 1'b1) && (step === 3'(i));
        if (poke && i == 0 && c == 0) sw[9] = ~sw[9];
        tick();
      end
      chk("show_on", on_ok, 1);
      for (int c = 0; c < m_sc; c++) begin
        off_ok &= (led === '0) && (busy === 1'b1) && (step === 3'(i)) && (fail === 1'b0);
        tick();
      end
      chk("show_off", off_ok, 1);
    end
    chk("input_entry_step", step, 0);
    chk("input_entry_busy", busy, 1);
  endtask

  task automatic win_inputs();
    int x;
    while (in_q.size() > 0) begin
      x = in_q[0];
      toggle(x);
      void'(in_q.pop_front());
      if (in_q.size() > 0) begin
        chk("echo_led", led, m_oh(x));
        chk("echo_busy", busy, 1);
      end else begin
        m_score = (m_score < 255) ? m_score + 1 : 255;
        chk("win_success", success, 1);
        chk("win_led", led, 10'h3FF);
        chk("win_score", score, m_score);
        chk("win_busy", busy, 0);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_led", led, 0);
    chk("rst_score", score, 0);
    chk("rst_success", success, 0);
    chk("rst_fail", fail, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    m_lfsr = 8'hA5;
    m_score = 0;
    reset = 1'b1;
    tick();

    // first round: sequence 0,5,2; echo lasts a single cycle
    do_start(0);
    watch_show(0);
    e = in_q.pop_front();
    toggle(e);
    chk("first_echo", led, m_oh(e));
    tick();
    chk("echo_one_cycle", led, 0);
    win_inputs();

    // restart from WIN, then keep winning until the score saturates
    do_start(0);
    watch_show(0);
    win_inputs();
    while (m_score < 255) begin
      do_start(0);
      watch_show(0);
      win_inputs();
    end
    do_start(0);
    watch_show(0);
    win_inputs();
    chk("score_saturated", score, 255);

    // toggle during SHOW_ON ignored; two bits at once loses
    do_start(0);
    watch_show(1);
    chk("poke_ignored", fail, 0);
    sw[4] = ~sw[4];
    sw[7] = ~sw[7];
    repeat (3) tick();
    chk("invalid_pending", fail, 0);
    tick();
    chk("invalid_lose", fail, 1);
    chk("invalid_led", led, 0);
    chk("invalid_score", score, m_score);
    in_q.delete();

    // no input: LOSE exactly 16 cycles after INPUT entry
    do_start(0);
    watch_show(0);
    repeat (15) tick();
    chk("timeout_wait", fail, 0);
    chk("timeout_wait_busy", busy, 1);
    tick();
    chk("timeout_lose", fail, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_score", score, m_score);
    in_q.delete();

    // toggle landing on the timeout cycle is accepted
    do_start(0);
    watch_show(0);
    repeat (12) tick();
    e = in_q.pop_front();
    toggle(e);
    chk("late_echo", led, m_oh(e));
    chk("late_nofail", fail, 0);
    win_inputs();

    // reset in the middle of SHOW_ON
    do_start(0);
    repeat (2) tick();
    chk("pre_reset_busy", busy, 1);
    reset = 1'b0;
    tick();
    chk("midrst_led", led, 0);
    chk("midrst_score", score, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_step", step, 0);
    chk("midrst_success", success, 0);
    reset = 1'b1;
    tick();
    m_lfsr = 8'hA5;
    m_score = 0;
    show_q.delete();
    in_q.delete();

    // difficulty 1: four elements, four-cycle show; wrong second press loses
    do_start(1);
    watch_show(0);
    e = in_q.pop_front();
    toggle(e);
    chk("d1_echo", led, m_oh(e));
    toggle(3);
    chk("wrong_lose", fail, 1);
    chk("wrong_score", score, 0);
    chk("wrong_busy", busy, 0);
    in_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
